// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, memory-stage and RAM-side signals of the unified RAM arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req/addr/data until their valid pulse; stalls are driven by the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // fetch-stage port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  // memory-stage port (LDD / STD / PUSH / POP)
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;

  // single-port RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_valid, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // pipeline stages plus RAM side
  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between fetch and memory stage, with a starvation guard for fetch.
// Latency: request to valid is RD_LAT+2 cycles for reads and 2 cycles for writes.
// Backpressure: the requester not being served sees its stall high until its own valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam int WAIT_W   = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Request as it is presented to the RAM; latched once per grant.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t              state, state_nxt;
  owner_t              owner, owner_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  req_t                ram_req, ram_req_nxt;
  logic                ram_en_q, ram_en_nxt;
  logic                if_valid_q, if_valid_nxt;
  logic                mem_valid_q, mem_valid_nxt;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_nxt;

  req_t if_cand;
  req_t mem_cand;
  logic streak_full;
  logic if_wins;

  // Fetch never writes, so its candidate carries a zero write word.
  assign if_cand  = '{we: 1'b0, addr: bus.if_addr, wdata: '0};
  assign mem_cand = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};

  // Memory stage normally wins; fetch is forced through once MEM has won MAX_STREAK times in a row
  // while fetch was waiting.
  assign streak_full = (streak == STREAK_W'(MAX_STREAK));
  assign if_wins     = bus.if_req & (~bus.mem_req | streak_full);

  // Next-state and next registered-output logic for the grant FSM and RAM read sequencer.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    streak_nxt    = streak;
    wait_cnt_nxt  = wait_cnt;
    ram_req_nxt   = ram_req;
    ram_en_nxt    = 1'b0;
    if_valid_nxt  = 1'b0;
    mem_valid_nxt = 1'b0;
    if_rdata_nxt  = if_rdata_q;
    mem_rdata_nxt = mem_rdata_q;

    case (state)
      IDLE: begin
        if (bus.if_req | bus.mem_req) begin
          state_nxt  = ISSUE;
          ram_en_nxt = 1'b1;
          if (if_wins) begin
            owner_nxt   = OWN_IF;
            ram_req_nxt = if_cand;
            streak_nxt  = '0;
          end else begin
            owner_nxt   = OWN_MEM;
            ram_req_nxt = mem_cand;
            if (bus.if_req) begin
              if (!streak_full) begin
                streak_nxt = streak + STREAK_W'(1);
              end
            end else begin
              streak_nxt = '0;
            end
          end
        end
      end

      ISSUE: begin
        wait_cnt_nxt = '0;
        if (ram_req.we) begin
          // Writes complete as soon as the strobe has been issued.
          state_nxt = RESP;
          if (owner == OWN_IF) begin
            if_valid_nxt = 1'b1;
          end else begin
            mem_valid_nxt = 1'b1;
          end
        end else begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
          // Last wait cycle: RAM data is valid now, capture it for the owner only.
          state_nxt = RESP;
          if (owner == OWN_IF) begin
            if_valid_nxt = 1'b1;
            if_rdata_nxt = bus.ram_rdata;
          end else begin
            mem_valid_nxt = 1'b1;
            mem_rdata_nxt = bus.ram_rdata;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      RESP: begin
        // Always return to IDLE; the next grant is evaluated there.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      streak      <= '0;
      wait_cnt    <= '0;
      ram_req     <= '0;
      ram_en_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      streak      <= streak_nxt;
      wait_cnt    <= wait_cnt_nxt;
      ram_req     <= ram_req_nxt;
      ram_en_q    <= ram_en_nxt;
      if_valid_q  <= if_valid_nxt;
      mem_valid_q <= mem_valid_nxt;
      if_rdata_q  <= if_rdata_nxt;
      mem_rdata_q <= mem_rdata_nxt;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_req.we;
  assign bus.ram_addr  = ram_req.addr;
  assign bus.ram_wdata = ram_req.wdata;

  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rdata = mem_rdata_q;

  // Stalls are combinational so a requester freezes in the same cycle it raises req.
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.mem_stall = bus.mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed check of mem_port_arbiter with RD_LAT=1 (instance a) and RD_LAT=3 (instance b).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: requesters hold req until valid, as a frozen pipeline stage would.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   g;
  int   en_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ia ();
  mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ib ();

  mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .RD_LAT(1), .MAX_STREAK(3)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ia)
  );

  mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .RD_LAT(3), .MAX_STREAK(3)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ib)
  );

  // RAM contents: written words override a fixed background image.
  logic [15:0] mem_a [int];
  logic [15:0] mem_b [int];
  logic [15:0] b_s1, b_s2;

  function automatic logic [15:0] background(input logic [19:0] a);
    case (a)
      20'h00010: return 16'hBEEF;
      20'h00020: return 16'h5A5A;
      20'h00030: return 16'hC3C3;
      20'h00005: return 16'hA5A5;
      default:   return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rd_a(input logic [19:0] a);
    if (mem_a.exists(int'(a))) return mem_a[int'(a)];
    return background(a);
  endfunction

  function automatic logic [15:0] rd_b(input logic [19:0] a);
    if (mem_b.exists(int'(a))) return mem_b[int'(a)];
    return background(a);
  endfunction

  // RAM model a: one-cycle read latency; data is only valid in the single cycle after ram_en.
  always @(posedge clk) begin
    if (ia.ram_en && ia.ram_we) mem_a[int'(ia.ram_addr)] = ia.ram_wdata;
    ia.ram_rdata <= (ia.ram_en && !ia.ram_we) ? rd_a(ia.ram_addr) : 16'hDEAD;
  end

  // RAM model b: three-cycle read latency pipeline.
  always @(posedge clk) begin
    if (ib.ram_en && ib.ram_we) mem_b[int'(ib.ram_addr)] = ib.ram_wdata;
    b_s1         <= (ib.ram_en && !ib.ram_we) ? rd_b(ib.ram_addr) : 16'hDEAD;
    b_s2         <= b_s1;
    ib.ram_rdata <= b_s2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ia.if_req = 1'b0; ia.if_addr = '0;
    ia.mem_req = 1'b0; ia.mem_we = 1'b0; ia.mem_addr = '0; ia.mem_wdata = '0;
    ib.if_req = 1'b0; ib.if_addr = '0;
    ib.mem_req = 1'b0; ib.mem_we = 1'b0; ib.mem_addr = '0; ib.mem_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ram_en",    32'(ia.ram_en),    32'h0);
    chk("rst_ram_we",    32'(ia.ram_we),    32'h0);
    chk("rst_ram_addr",  32'(ia.ram_addr),  32'h0);
    chk("rst_ram_wdata", 32'(ia.ram_wdata), 32'h0);
    chk("rst_if_valid",  32'(ia.if_valid),  32'h0);
    chk("rst_mem_valid", 32'(ia.mem_valid), 32'h0);
    chk("rst_if_rdata",  32'(ia.if_rdata),  32'h0);
    chk("rst_mem_rdata", 32'(ia.mem_rdata), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: fetch read of 0x10
    ia.if_req = 1'b1; ia.if_addr = 20'h00010;
    #1 chk("t1_stall_t0", 32'(ia.if_stall), 32'h1);
    chk("t1_mem_stall", 32'(ia.mem_stall), 32'h0);
    @(negedge clk);
    chk("t1_en_t1",    32'(ia.ram_en),   32'h1);
    chk("t1_we_t1",    32'(ia.ram_we),   32'h0);
    chk("t1_addr_t1",  32'(ia.ram_addr), 32'h10);
    chk("t1_stall_t1", 32'(ia.if_stall), 32'h1);
    @(negedge clk);
    chk("t1_en_t2",    32'(ia.ram_en),   32'h0);
    chk("t1_valid_t2", 32'(ia.if_valid), 32'h0);
    chk("t1_stall_t2", 32'(ia.if_stall), 32'h1);
    @(negedge clk);
    chk("t1_valid_t3", 32'(ia.if_valid),  32'h1);
    chk("t1_rdata_t3", 32'(ia.if_rdata),  32'hBEEF);
    chk("t1_stall_t3", 32'(ia.if_stall),  32'h0);
    chk("t1_mvalid",   32'(ia.mem_valid), 32'h0);
    ia.if_req = 1'b0;
    @(negedge clk);
    chk("t1_valid_t4", 32'(ia.if_valid), 32'h0);
    chk("t1_hold_t4",  32'(ia.if_rdata), 32'hBEEF);
    chk("t1_en_t4",    32'(ia.ram_en),   32'h0);

    // 2: memory-stage write to the top address, then read it back
    ia.mem_req = 1'b1; ia.mem_we = 1'b1; ia.mem_addr = 20'hFFFFF; ia.mem_wdata = 16'h1234;
    #1 chk("t2_stall_t0", 32'(ia.mem_stall), 32'h1);
    @(negedge clk);
    chk("t2_en_t1",    32'(ia.ram_en),    32'h1);
    chk("t2_we_t1",    32'(ia.ram_we),    32'h1);
    chk("t2_addr_t1",  32'(ia.ram_addr),  32'hFFFFF);
    chk("t2_wdata_t1", 32'(ia.ram_wdata), 32'h1234);
    @(negedge clk);
    chk("t2_valid_t2", 32'(ia.mem_valid), 32'h1);
    chk("t2_rdata_wr", 32'(ia.mem_rdata), 32'h0);
    chk("t2_ivalid",   32'(ia.if_valid),  32'h0);
    ia.mem_we = 1'b0;
    @(negedge clk);
    chk("t2r_en_t0",    32'(ia.ram_en),    32'h0);
    chk("t2r_valid_t0", 32'(ia.mem_valid), 32'h0);
    @(negedge clk);
    chk("t2r_en_t1",   32'(ia.ram_en),   32'h1);
    chk("t2r_we_t1",   32'(ia.ram_we),   32'h0);
    chk("t2r_addr_t1", 32'(ia.ram_addr), 32'hFFFFF);
    @(negedge clk);
    chk("t2r_valid_t2", 32'(ia.mem_valid), 32'h0);
    @(negedge clk);
    chk("t2r_valid_t3", 32'(ia.mem_valid), 32'h1);
    chk("t2r_rdata_t3", 32'(ia.mem_rdata), 32'h1234);
    chk("t2r_if_hold",  32'(ia.if_rdata),  32'hBEEF);
    ia.mem_req = 1'b0;
    @(negedge clk);

    // 3: simultaneous requests, MEM first then IF
    ia.if_req = 1'b1; ia.if_addr = 20'h00010;
    ia.mem_req = 1'b1; ia.mem_we = 1'b0; ia.mem_addr = 20'h00020;
    en_cnt = 0;
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_addr_t1", 32'(ia.ram_addr), 32'h20);
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_istall_t2", 32'(ia.if_stall),  32'h1);
    chk("t3_mstall_t2", 32'(ia.mem_stall), 32'h1);
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_mvalid_t3", 32'(ia.mem_valid), 32'h1);
    chk("t3_mrdata_t3", 32'(ia.mem_rdata), 32'h5A5A);
    chk("t3_ivalid_t3", 32'(ia.if_valid),  32'h0);
    chk("t3_istall_t3", 32'(ia.if_stall),  32'h1);
    ia.mem_req = 1'b0;
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_en_t4", 32'(ia.ram_en), 32'h0);
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_en_t5",   32'(ia.ram_en),   32'h1);
    chk("t3_addr_t5", 32'(ia.ram_addr), 32'h10);
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    @(negedge clk);
    en_cnt += int'(ia.ram_en);
    chk("t3_ivalid_t7", 32'(ia.if_valid),  32'h1);
    chk("t3_irdata_t7", 32'(ia.if_rdata),  32'hBEEF);
    chk("t3_mvalid_t7", 32'(ia.mem_valid), 32'h0);
    chk("t3_en_count",  32'(en_cnt),       32'd2);
    ia.if_req = 1'b0;
    @(negedge clk);

    // 4: MEM held continuously with fetch pending: M M M I M M M I
    ia.if_req = 1'b1; ia.if_addr = 20'h00010;
    ia.mem_req = 1'b1; ia.mem_we = 1'b0; ia.mem_addr = 20'h00030;
    g = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ia.ram_en) begin
        chk("t4_grant_addr", 32'(ia.ram_addr), ((g % 4) == 3) ? 32'h10 : 32'h30);
        g++;
      end
      if (ia.if_valid && g >= 8) break;
    end
    ia.if_req = 1'b0; ia.mem_req = 1'b0;
    chk("t4_grant_count", 32'(g),         32'd8);
    chk("t4_mem_rdata",   32'(ia.mem_rdata), 32'hC3C3);
    @(negedge clk);

    // 5: reset in the WAIT cycle of a read
    ia.mem_req = 1'b1; ia.mem_we = 1'b0; ia.mem_addr = 20'h00030;
    @(negedge clk);
    chk("t5_en_t1", 32'(ia.ram_en), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_en_rst",     32'(ia.ram_en),    32'h0);
    chk("t5_mvalid_rst", 32'(ia.mem_valid), 32'h0);
    chk("t5_ivalid_rst", 32'(ia.if_valid),  32'h0);
    chk("t5_addr_rst",   32'(ia.ram_addr),  32'h0);
    chk("t5_mrdata_rst", 32'(ia.mem_rdata), 32'h0);
    chk("t5_irdata_rst", 32'(ia.if_rdata),  32'h0);
    reset = 1'b0; ia.mem_req = 1'b0;
    @(negedge clk);
    chk("t5_en_after",     32'(ia.ram_en),    32'h0);
    chk("t5_mvalid_after", 32'(ia.mem_valid), 32'h0);
    ia.if_req = 1'b1; ia.if_addr = 20'h00010;
    @(negedge clk);
    chk("t5_new_en", 32'(ia.ram_en), 32'h1);
    @(negedge clk);
    chk("t5_new_valid_t2", 32'(ia.if_valid), 32'h0);
    @(negedge clk);
    chk("t5_new_valid_t3", 32'(ia.if_valid), 32'h1);
    chk("t5_new_rdata",    32'(ia.if_rdata), 32'hBEEF);
    ia.if_req = 1'b0;
    @(negedge clk);

    // 6: RD_LAT=3 read of 0x5, then write and read back
    ib.mem_req = 1'b1; ib.mem_we = 1'b0; ib.mem_addr = 20'h00005;
    @(negedge clk);
    chk("t6_en_t1",   32'(ib.ram_en),   32'h1);
    chk("t6_addr_t1", 32'(ib.ram_addr), 32'h5);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("t6_valid_early", 32'(ib.mem_valid), 32'h0);
    end
    @(negedge clk);
    chk("t6_valid_t5", 32'(ib.mem_valid), 32'h1);
    chk("t6_rdata_t5", 32'(ib.mem_rdata), 32'hA5A5);
    ib.mem_req = 1'b0;
    @(negedge clk);
    ib.mem_req = 1'b1; ib.mem_we = 1'b1; ib.mem_wdata = 16'h0F0F;
    @(negedge clk);
    chk("t6w_en_t1", 32'(ib.ram_en), 32'h1);
    chk("t6w_we_t1", 32'(ib.ram_we), 32'h1);
    @(negedge clk);
    chk("t6w_valid_t2", 32'(ib.mem_valid), 32'h1);
    chk("t6w_rdata_t2", 32'(ib.mem_rdata), 32'hA5A5);
    ib.mem_req = 1'b0;
    @(negedge clk);
    ib.mem_req = 1'b1; ib.mem_we = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6r_valid_t4", 32'(ib.mem_valid), 32'h0);
    @(negedge clk);
    chk("t6r_valid_t5", 32'(ib.mem_valid), 32'h1);
    chk("t6r_rdata_t5", 32'(ib.mem_rdata), 32'h0F0F);
    ib.mem_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
